// File: rtl/adder_arb_pkg.sv
// Shared types and default sizes for the adder arbiter.
// Optional saturating mode is selected in adder_arbiter by ADDER_ARB_SAT_EN.
package adder_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  localparam int DEF_W     = 4;
  localparam int DEF_CNT_W = 8;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter: combinational grant, last-granted pointer
// that advances only when a grant is issued (grant implies acceptance).
module rr_arb2
  import adder_arb_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [1:0] valid,
  output logic [1:0] grant
);

  logic last_reg;

  // Contention goes to the requester that did not win last; a lone requester always wins.
  always_comb begin
    grant = 2'b00;
    if (en) begin
      if (valid == 2'b11) begin
        grant = last_reg ? 2'b01 : 2'b10;
      end else begin
        grant = valid;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_reg <= 1'b1;
    end else if (grant[0]) begin
      last_reg <= 1'b0;
    end else if (grant[1]) begin
      last_reg <= 1'b1;
    end
  end

endmodule

// File: rtl/adder_arbiter.sv
// One shared W-bit adder serving two requesters, round-robin, one result in flight.
// Define ADDER_ARB_SAT_EN to saturate res_sum to all-ones on carry-out.
module adder_arbiter
  import adder_arb_pkg::*;
#(
  parameter int W     = DEF_W,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic             req0_valid,
  input  logic [W-1:0]     req0_a,
  input  logic [W-1:0]     req0_b,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [W-1:0]     req1_a,
  input  logic [W-1:0]     req1_b,
  output logic             req1_ready,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [W-1:0]     res_sum,
  output logic             res_carry,
  output logic             res_id,
  output logic [CNT_W-1:0] grant_cnt0,
  output logic [CNT_W-1:0] grant_cnt1
);

  state_t                  state_reg;
  logic                    valid_reg;
  logic [W-1:0]            sum_reg;
  logic                    carry_reg;
  logic                    id_reg;
  logic [1:0]              grant;
  logic                    arb_en;
  logic [W-1:0]            a_sel;
  logic [W-1:0]            b_sel;
  logic [W:0]              sum_full;
  logic [W-1:0]            sum_next;
  logic [1:0][CNT_W-1:0]   cnt_all;

  // Gating with rst_n keeps both readies low while reset is held.
  assign arb_en = rst_n && ena && (state_reg == IDLE);

  rr_arb2 u_rr_arb2 (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (arb_en),
    .valid ({req1_valid, req0_valid}),
    .grant (grant)
  );

  assign req0_ready = grant[0];
  assign req1_ready = grant[1];

  assign a_sel    = grant[1] ? req1_a : req0_a;
  assign b_sel    = grant[1] ? req1_b : req0_b;
  assign sum_full = {1'b0, a_sel} + {1'b0, b_sel};

`ifdef ADDER_ARB_SAT_EN
  assign sum_next = sum_full[W] ? {W{1'b1}} : sum_full[W-1:0];
`else
  assign sum_next = sum_full[W-1:0];
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      valid_reg <= 1'b0;
      sum_reg   <= '0;
      carry_reg <= 1'b0;
      id_reg    <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (|grant) begin
            state_reg <= HOLD;
            valid_reg <= 1'b1;
            sum_reg   <= sum_next;
            carry_reg <= sum_full[W];
            id_reg    <= grant[1];
          end
        end
        HOLD: begin
          if (res_ready) begin
            state_reg <= IDLE;
            valid_reg <= 1'b0;
          end
        end
        default: begin
          state_reg <= IDLE;
          valid_reg <= 1'b0;
        end
      endcase
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_cnt
      logic [CNT_W-1:0] cnt_reg;
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          cnt_reg <= '0;
        end else if (grant[gi]) begin
          cnt_reg <= cnt_reg + 1'b1;
        end
      end
      assign cnt_all[gi] = cnt_reg;
    end
  endgenerate

  assign res_valid  = valid_reg;
  assign res_sum    = sum_reg;
  assign res_carry  = carry_reg;
  assign res_id     = id_reg;
  assign grant_cnt0 = cnt_all[0];
  assign grant_cnt1 = cnt_all[1];

endmodule

// File: tb/tb_adder_arbiter.sv
// Randomized self-checking bench for adder_arbiter against a transaction-level model.
module tb_adder_arbiter;

  localparam int W     = 4;
  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             ena = 1'b0;
  logic             req0_valid = 1'b0;
  logic [W-1:0]     req0_a = '0;
  logic [W-1:0]     req0_b = '0;
  logic             req0_ready;
  logic             req1_valid = 1'b0;
  logic [W-1:0]     req1_a = '0;
  logic [W-1:0]     req1_b = '0;
  logic             req1_ready;
  logic             res_valid;
  logic             res_ready = 1'b0;
  logic [W-1:0]     res_sum;
  logic             res_carry;
  logic             res_id;
  logic [CNT_W-1:0] grant_cnt0;
  logic [CNT_W-1:0] grant_cnt1;

  int errors = 0;
  int checks = 0;

  // Model state: is a result outstanding, who won last, what the result must be.
  bit busy;
  int last;
  int m_sum;
  int m_carry;
  int m_id;
  int m_cnt[2];

  adder_arbiter #(.W(W), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ena        (ena),
    .req0_valid (req0_valid),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .req1_ready (req1_ready),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_sum    (res_sum),
    .res_carry  (res_carry),
    .res_id     (res_id),
    .grant_cnt0 (grant_cnt0),
    .grant_cnt1 (grant_cnt1)
  );

  always #5 clk = ~clk;

  function automatic void calc_ready(output bit r0, output bit r1);
    bit open;
    open = rst_n && ena && !busy;
    r0 = open && req0_valid && (!req1_valid || last == 1);
    r1 = open && req1_valid && (!req0_valid || last == 0);
  endfunction

  function automatic int exp_sum(input int a, input int b);
    int total;
    total = a + b;
`ifdef ADDER_ARB_SAT_EN
    if (total >= (1 << W)) return (1 << W) - 1;
    return total;
`else
    return total % (1 << W);
`endif
  endfunction

  // Advance one clock and update the model from the inputs seen at that edge.
  task automatic tick();
    bit r0, r1;
    int a, b;
    calc_ready(r0, r1);
    @(posedge clk);
    if (!rst_n) begin
      busy = 0; last = 1; m_sum = 0; m_carry = 0; m_id = 0;
      m_cnt[0] = 0; m_cnt[1] = 0;
    end else if (busy) begin
      if (res_ready) busy = 0;
    end else if (r0 || r1) begin
      m_id = r0 ? 0 : 1;
      a = r0 ? int'(req0_a) : int'(req1_a);
      b = r0 ? int'(req0_b) : int'(req1_b);
      m_sum = exp_sum(a, b);
      m_carry = (a + b >= (1 << W)) ? 1 : 0;
      m_cnt[m_id] = (m_cnt[m_id] + 1) % (1 << CNT_W);
      last = m_id;
      busy = 1;
    end
    #1;
  endtask

  task automatic test_reset();
    rst_n = 0; ena = 1; req0_valid = 1; req1_valid = 1; res_ready = 0;
    #1;
    checks++;
    if ({req1_ready, req0_ready} !== 2'b00) begin
      errors++; $display("FAIL reset_ready: got %b want 00", {req1_ready, req0_ready});
    end
    tick(); tick();
    checks++;
    if ({res_valid, res_sum, res_carry, res_id} !== '0) begin
      errors++; $display("FAIL reset_res: got v=%b s=%h c=%b id=%b want all 0",
                         res_valid, res_sum, res_carry, res_id);
    end
    checks++;
    if (grant_cnt0 !== 0 || grant_cnt1 !== 0) begin
      errors++; $display("FAIL reset_cnt: got %0d/%0d want 0/0", grant_cnt0, grant_cnt1);
    end
    req0_valid = 0; req1_valid = 0; rst_n = 1;
    tick();
    $display("test_reset done");
  endtask

  task automatic test_single();
    req0_valid = 1; req0_a = 4'd3; req0_b = 4'd4; req1_valid = 0; res_ready = 0;
    #1;
    checks++;
    if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
      errors++; $display("FAIL single_ready: got %b%b want 01", req1_ready, req0_ready);
    end
    tick();
    req0_valid = 0;
    checks++;
    if (res_valid !== 1'b1 || res_sum !== 4'd7 || res_carry !== 1'b0 || res_id !== 1'b0) begin
      errors++; $display("FAIL single_res: got v=%b s=%0d c=%b id=%b want v=1 s=7 c=0 id=0",
                         res_valid, res_sum, res_carry, res_id);
    end
    checks++;
    if (grant_cnt0 !== 8'd1) begin
      errors++; $display("FAIL single_cnt: got %0d want 1", grant_cnt0);
    end
    res_ready = 1;
    tick();
    checks++;
    if (res_valid !== 1'b0) begin
      errors++; $display("FAIL single_drain: res_valid got %b want 0", res_valid);
    end
    $display("test_single done");
  endtask

  task automatic test_alternate();
    int want_id;
    rst_n = 0; tick(); rst_n = 1;
    ena = 1; res_ready = 1; req0_valid = 1; req1_valid = 1;
    want_id = 0;
    for (int i = 0; i < 8; i++) begin
      req0_a = W'($urandom); req0_b = W'($urandom);
      req1_a = W'($urandom); req1_b = W'($urandom);
      tick();
      checks++;
      if (res_valid !== 1'(i % 2 == 0)) begin
        errors++; $display("FAIL alt_valid[%0d]: got %b want %b", i, res_valid, i % 2 == 0);
      end
      if (i % 2 == 0) begin
        checks++;
        if (res_id !== 1'(want_id) || res_sum !== W'(m_sum) || res_carry !== 1'(m_carry)) begin
          errors++; $display("FAIL alt_res[%0d]: got id=%b s=%h c=%b want id=%0d s=%h c=%0d",
                             i, res_id, res_sum, res_carry, want_id, m_sum, m_carry);
        end
        want_id = 1 - want_id;
      end
    end
    req0_valid = 0; req1_valid = 0;
    tick();
    $display("test_alternate done");
  endtask

  task automatic test_hold();
    req0_valid = 0; req1_valid = 1; req1_a = 4'hF; req1_b = 4'h2; res_ready = 0; ena = 1;
    tick();
    req0_valid = 1; req1_valid = 1;
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++;
      if ({req1_ready, req0_ready} !== 2'b00) begin
        errors++; $display("FAIL hold_ready[%0d]: got %b want 00", i, {req1_ready, req0_ready});
      end
      checks++;
`ifdef ADDER_ARB_SAT_EN
      if (res_valid !== 1'b1 || res_sum !== 4'hF || res_carry !== 1'b1 || res_id !== 1'b1) begin
        errors++; $display("FAIL hold_res[%0d]: got v=%b s=%h c=%b id=%b want 1 F 1 1",
                           i, res_valid, res_sum, res_carry, res_id);
      end
`else
      if (res_valid !== 1'b1 || res_sum !== 4'h1 || res_carry !== 1'b1 || res_id !== 1'b1) begin
        errors++; $display("FAIL hold_res[%0d]: got v=%b s=%h c=%b id=%b want 1 1 1 1",
                           i, res_valid, res_sum, res_carry, res_id);
      end
`endif
      tick();
    end
    req0_valid = 0; req1_valid = 0; res_ready = 1;
    tick();
    checks++;
    if (res_valid !== 1'b0) begin
      errors++; $display("FAIL hold_drain: res_valid got %b want 0", res_valid);
    end
    $display("test_hold done");
  endtask

  task automatic test_wrap();
    rst_n = 0; tick(); rst_n = 1;
    ena = 1; res_ready = 1; req1_valid = 0; req0_valid = 1;
    for (int i = 1; i <= 256; i++) begin
      req0_a = W'($urandom); req0_b = W'($urandom);
      tick(); tick();
      if (i == 255 || i == 256) begin
        checks++;
        if (grant_cnt0 !== CNT_W'(m_cnt[0]) || grant_cnt0 !== CNT_W'(i % 256)) begin
          errors++; $display("FAIL wrap_cnt[%0d]: got %0d want %0d", i, grant_cnt0, i % 256);
        end
      end
    end
    req0_valid = 0;
    tick();
    $display("test_wrap done");
  endtask

  task automatic test_reset_mid();
    ena = 1; res_ready = 0; req0_valid = 1; req1_valid = 1;
    tick();
    checks++;
    if (res_valid !== 1'b1 || grant_cnt0 + grant_cnt1 === 0) begin
      errors++; $display("FAIL rstmid_pre: got v=%b cnt=%0d/%0d want v=1 cnt nonzero",
                         res_valid, grant_cnt0, grant_cnt1);
    end
    rst_n = 0;
    tick();
    checks++;
    if (res_valid !== 1'b0 || grant_cnt0 !== 0 || grant_cnt1 !== 0) begin
      errors++; $display("FAIL rstmid_post: got v=%b cnt=%0d/%0d want v=0 cnt 0/0",
                         res_valid, grant_cnt0, grant_cnt1);
    end
    rst_n = 1;
    #1;
    checks++;
    if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
      errors++; $display("FAIL rstmid_idle: ready got %b%b want 01", req1_ready, req0_ready);
    end
    req0_valid = 0; req1_valid = 0;
    tick();
    $display("test_reset_mid done");
  endtask

  task automatic test_ena();
    bit r0, r1;
    ena = 0; res_ready = 1; req0_valid = 1; req1_valid = 1;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if ({req1_ready, req0_ready} !== 2'b00 || res_valid !== 1'b0) begin
        errors++; $display("FAIL ena_off[%0d]: ready got %b v=%b want 00 v=0",
                           i, {req1_ready, req0_ready}, res_valid);
      end
      tick();
    end
    ena = 1;
    #1;
    calc_ready(r0, r1);
    checks++;
    if (req0_ready !== r0 || req1_ready !== r1 || (r0 == r1)) begin
      errors++; $display("FAIL ena_on: ready got %b%b want %b%b", req1_ready, req0_ready, r1, r0);
    end
    tick();
    req0_valid = 0; req1_valid = 0;
    tick();
    $display("test_ena done");
  endtask

  task automatic test_random();
    bit r0, r1;
    for (int i = 0; i < 400; i++) begin
      ena        = ($urandom_range(0, 7) != 0);
      res_ready  = ($urandom_range(0, 2) != 0);
      req0_valid = $urandom_range(0, 1) == 1;
      req1_valid = $urandom_range(0, 1) == 1;
      req0_a = W'($urandom); req0_b = W'($urandom);
      req1_a = W'($urandom); req1_b = W'($urandom);
      #1;
      calc_ready(r0, r1);
      checks++;
      if (req0_ready !== r0 || req1_ready !== r1) begin
        errors++; $display("FAIL rand_ready[%0d]: got %b%b want %b%b",
                           i, req1_ready, req0_ready, r1, r0);
      end
      tick();
      checks++;
      if (res_valid !== busy || res_sum !== W'(m_sum) || res_carry !== 1'(m_carry) ||
          res_id !== 1'(m_id) || grant_cnt0 !== CNT_W'(m_cnt[0]) ||
          grant_cnt1 !== CNT_W'(m_cnt[1])) begin
        errors++; $display("FAIL rand_res[%0d]: got v=%b s=%h c=%b id=%b cnt=%0d/%0d want v=%b s=%h c=%0d id=%0d cnt=%0d/%0d",
                           i, res_valid, res_sum, res_carry, res_id, grant_cnt0, grant_cnt1,
                           busy, m_sum, m_carry, m_id, m_cnt[0], m_cnt[1]);
      end
    end
    $display("test_random done");
  endtask

  initial begin
    busy = 0; last = 1; m_sum = 0; m_carry = 0; m_id = 0; m_cnt[0] = 0; m_cnt[1] = 0;
    @(negedge clk);
    test_reset();
    test_single();
    test_alternate();
    test_hold();
    test_wrap();
    test_reset_mid();
    test_ena();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/adder_arbiter.md
ADDER_ARBITER -- requirements
Module: adder_arbiter

Interface
REQ-001 Parameter W, default 4, operand and sum width in bits.
REQ-002 Parameter CNT_W, default 8, width of the per-requester grant counters.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 ena  input  1  when low, no new grants; an in-flight result is still held and delivered.
REQ-006 req0_valid, req1_valid  input  1 each  requester 0/1 has an operand pair.
REQ-007 req0_a, req0_b, req1_a, req1_b  input  W each  operands per requester.
REQ-008 req0_ready, req1_ready  output  1 each  pair accepted this cycle when valid&&ready.
REQ-009 res_valid  output  1  result available.
REQ-010 res_ready  input  1  consumer accepts result when res_valid&&res_ready.
REQ-011 res_sum  output  W  sum (or saturated sum, see REQ-031).
REQ-012 res_carry  output  1  carry-out of the W-bit add.
REQ-013 res_id  output  1  requester that produced the result.
REQ-014 grant_cnt0, grant_cnt1  output  CNT_W each  accepted-request counters.

Function
REQ-015 The block SHALL share one W-bit adder between two requesters, one operation at a time.
REQ-016 FSM states SHALL be IDLE and HOLD; IDLE->HOLD on acceptance, HOLD->IDLE on result handshake.
REQ-017 In IDLE with ena=1, ready SHALL be asserted combinationally to exactly one valid requester chosen by round-robin; no ready in HOLD or when ena=0.
REQ-018 Round-robin: a last-granted pointer (reset 1) gives priority to the other requester; the pointer updates only on acceptance.
REQ-019 A lone valid requester SHALL be granted regardless of the pointer.
REQ-020 On acceptance the operands SHALL be added with W+1-bit result registered; res_valid SHALL rise the next cycle (latency 1).
REQ-021 res_sum, res_carry, res_id SHALL hold stable while res_valid=1 and res_ready=0.
REQ-022 On result handshake the block SHALL return to IDLE; a new grant is possible no earlier than the following cycle (max throughput one result per 2 cycles).
REQ-023 grant_cntN SHALL increment by 1 on each acceptance from requester N and wrap from 2^CNT_W-1 to 0.
REQ-024 Requester valid deasserting without handshake SHALL have no effect on state.

Reset
REQ-025 With rst_n=0 at a rising clk edge: state=IDLE, res_valid=0, res_sum=0, res_carry=0, res_id=0, counters=0, pointer=1.
REQ-026 Reset mid-operation SHALL discard a held result with no handshake emitted.
REQ-027 During reset all ready outputs SHALL be 0.

Configuration
REQ-028 Macro ADDER_ARB_SAT_EN selects saturating mode.
REQ-029 Without ADDER_ARB_SAT_EN, res_sum SHALL be the modulo-2^W sum.
REQ-030 res_carry SHALL report the true carry in both modes.
REQ-031 With ADDER_ARB_SAT_EN, res_sum SHALL be all-ones when carry=1, else the sum.

Structure
REQ-032 Package adder_arb_pkg SHALL hold the FSM state enum (IDLE, HOLD) and default W/CNT_W constants.
REQ-033 Sub-module rr_arb2 SHALL implement the two-way round-robin grant and pointer.

Verification
REQ-034 Reset, then req0 only a=3 b=4 -> next cycle res_valid, sum=7, carry=0, id=0, grant_cnt0=1.
REQ-035 Both valid every cycle after reset, res_ready=1 -> ids alternate 0,1,0,1; one result per 2 cycles.
REQ-036 req1 a=F b=2, res_ready=0 for 5 cycles -> res_valid held, sum=1 (unsat) or F (SAT_EN), carry=1, no ready asserted.
REQ-037 256 accepts from req0 with CNT_W=8 -> grant_cnt0 wraps to 0.
REQ-038 rst_n=0 while res_valid=1 -> next cycle res_valid=0, counters 0, IDLE.
REQ-039 ena=0 with both valid -> no ready; ena=1 -> grant resumes per pointer.
